// File: rtl/field_mul_arb.sv
// Round-robin share of one fixed-latency GF(2^61-1) multiplier across N_REQ requesters.
// Issue is combinational on grant, result is held at issue+MUL_LAT+1; a requester stays blocked until its result is taken.
module field_mul_arb #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 61,
    parameter int MUL_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       res_valid,
    output logic [N_REQ*WIDTH-1:0] res_data,
    input  logic [N_REQ-1:0]       res_ready,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic                   mul_in_valid,
    input  logic [WIDTH-1:0]       mul_out,
    input  logic                   mul_out_valid,
    output logic                   err
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] busy;
    logic [ID_W-1:0]  ptr;
    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_id;
    logic [WIDTH-1:0] gnt_a;
    logic [WIDTH-1:0] gnt_b;
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    logic             tag_vld [MUL_LAT];
    logic [ID_W-1:0]  tag_id  [MUL_LAT];
    logic [WIDTH-1:0] res_q   [N_REQ];
    logic             tail_vld;
    logic [ID_W-1:0]  tail_id;
    int               rr_idx;

    assign tail_vld = tag_vld[MUL_LAT-1];
    assign tail_id  = tag_id[MUL_LAT-1];

    // Scan farthest-first so the last hit, the one nearest ptr+1, wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        gnt_a   = '0;
        gnt_b   = '0;
        rr_idx  = 0;
        if (!rst) begin
            for (int k = N_REQ; k >= 1; k--) begin
                rr_idx = (int'(ptr) + k) % N_REQ;
                if (req_valid[rr_idx] && !busy[rr_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ID_W'(rr_idx);
                    gnt_a   = req_a[rr_idx*WIDTH +: WIDTH];
                    gnt_b   = req_b[rr_idx*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign req_ready    = gnt_vld ? (N_REQ'(1) << gnt_id) : '0;
    assign mul_in_valid = gnt_vld;
    assign mul_a        = gnt_vld ? gnt_a : last_a;
    assign mul_b        = gnt_vld ? gnt_b : last_b;

    always_ff @(posedge clk) begin
        if (gnt_vld) begin
            last_a <= gnt_a;
            last_b <= gnt_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= ID_W'(N_REQ - 1);
            busy      <= '0;
            res_valid <= '0;
            err       <= 1'b0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= '0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            tag_vld[0] <= gnt_vld;
            tag_id[0]  <= gnt_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            // Capture follows our own tag only; a disagreeing multiplier just flags.
            if (mul_out_valid != tail_vld) begin
                err <= 1'b1;
            end
            if (gnt_vld) begin
                ptr          <= gnt_id;
                busy[gnt_id] <= 1'b1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (res_valid[i] && res_ready[i]) begin
                    res_valid[i] <= 1'b0;
                    busy[i]      <= 1'b0;
                end
            end
            if (tail_vld) begin
                res_valid[tail_id] <= 1'b1;
                res_q[tail_id]     <= mul_out;
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_res
        assign res_data[i*WIDTH +: WIDTH] = res_q[i];
    end
endmodule

// File: tb/tb_field_mul_arb.sv
// Bench for field_mul_arb: a modular-multiplier model drives the multiplier port, and a
// queue-based reference of grants and in-flight products predicts every output each cycle.
module tb_field_mul_arb;
    localparam int N   = 4;
    localparam int W   = 61;
    localparam int LAT = 3;
    localparam logic [W-1:0] PRIME = '1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   res_valid;
    logic [N*W-1:0] res_data;
    logic [N-1:0]   res_ready = '0;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_in_valid;
    logic [W-1:0]   mul_out;
    logic           mul_out_valid;
    logic           err;
    logic           inject = 1'b0;

    field_mul_arb #(.N_REQ(N), .WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid),
        .mul_out(mul_out), .mul_out_valid(mul_out_valid), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W:0]     s;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        s = {1'b0, p[W-1:0]} + {1'b0, p[2*W-1:W]};
        if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
        return s[W-1:0];
    endfunction

    // External multiplier: fixed LAT pipeline, flushed by reset.
    logic [W-1:0] mp_dat [LAT];
    logic         mp_vld [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) mp_vld[k] <= 1'b0;
        end else begin
            mp_vld[0] <= mul_in_valid;
            mp_dat[0] <= mulmod(mul_a, mul_b);
            for (int k = 1; k < LAT; k++) begin
                mp_vld[k] <= mp_vld[k-1];
                mp_dat[k] <= mp_dat[k-1];
            end
        end
    end
    assign mul_out       = mp_dat[LAT-1];
    assign mul_out_valid = mp_vld[LAT-1] | inject;

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] prod;
    } fl_t;

    fl_t            infl[$];
    int             gnt_log[$];
    bit             mvld [N];
    logic [W-1:0]   mdat [N];
    int             mptr = N - 1;
    bit             merr = 1'b0;
    logic [W-1:0]   last_a, last_b;
    bit             have_last = 1'b0;
    int             cyc = 0;
    int             n_chk = 0;
    int             n_pass = 0;
    logic [N*W-1:0] nxt_a = '0;
    logic [N*W-1:0] nxt_b = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            logic [63:0] t;
            t = {$urandom(), $urandom()};
            nxt_a[i*W +: W] = t[W-1:0];
            t = {$urandom(), $urandom()};
            nxt_b[i*W +: W] = t[W-1:0];
        end
    endtask

    // One clock: drive, check against the reference, then advance the reference across the edge.
    task automatic tick(input bit r, input logic [N-1:0] rv, input logic [N-1:0] rr, input bit inj);
        logic [N-1:0]   busy, exp_rdy, exp_vld;
        logic [N*W-1:0] exp_dat;
        logic [W-1:0]   ga, gb;
        int             g, idx;
        bit             tail;
        fl_t            keep[$];
        @(negedge clk);
        rst = r; req_valid = rv; res_ready = rr; inject = inj;
        req_a = nxt_a; req_b = nxt_b;
        #1;
        for (int i = 0; i < N; i++) begin
            busy[i] = mvld[i];
            foreach (infl[k]) if (infl[k].id == i) busy[i] = 1'b1;
            exp_vld[i] = mvld[i];
            exp_dat[i*W +: W] = mdat[i];
        end
        g = -1;
        if (!r) begin
            for (int k = 1; k <= N && g < 0; k++) begin
                idx = (mptr + k) % N;
                if (rv[idx] && !busy[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            ga = req_a[g*W +: W];
            gb = req_b[g*W +: W];
            last_a = ga; last_b = gb; have_last = 1'b1;
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("mul_in_valid", mul_in_valid, g >= 0);
        if (have_last) begin
            chk("mul_a", mul_a, last_a);
            chk("mul_b", mul_b, last_b);
        end
        chk("res_valid", res_valid, exp_vld);
        chk("res_data", res_data, exp_dat);
        chk("err", err, merr);

        tail = 1'b0;
        foreach (infl[k]) if (infl[k].due == cyc + 1) tail = 1'b1;
        if (r) begin
            infl.delete();
            for (int i = 0; i < N; i++) begin mvld[i] = 1'b0; mdat[i] = '0; end
            mptr = N - 1;
            merr = 1'b0;
        end else begin
            if (mul_out_valid != tail) merr = 1'b1;
            for (int i = 0; i < N; i++) if (mvld[i] && rr[i]) mvld[i] = 1'b0;
            foreach (infl[k]) begin
                if (infl[k].due == cyc + 1) begin
                    mvld[infl[k].id] = 1'b1;
                    mdat[infl[k].id] = infl[k].prod;
                end else keep.push_back(infl[k]);
            end
            infl = keep;
            if (g >= 0) begin
                mptr = g;
                infl.push_back('{cyc + LAT + 1, g, mulmod(ga, gb)});
                gnt_log.push_back(g);
            end
        end
        cyc++;
    endtask

    initial begin
        int n, cnt;
        for (int i = 0; i < N; i++) begin mvld[i] = 1'b0; mdat[i] = '0; end
        repeat (2) @(posedge clk);
        tick(1, '1, '0, 0);
        chk("reset_no_grant", req_ready, 0);
        tick(0, '0, '0, 0);

        // Single op on requester 0: 5*7
        nxt_a = '0; nxt_b = '0;
        nxt_a[W-1:0] = 5; nxt_b[W-1:0] = 7;
        tick(0, 4'b0001, '0, 0);
        chk("single_grant", req_ready, 4'b0001);
        for (n = 1; n <= 20; n++) begin
            tick(0, '0, '0, 0);
            if (res_valid[0]) break;
        end
        chk("single_latency", n, LAT + 1);
        chk("single_product", res_data[W-1:0], 35);
        tick(0, '0, 4'b0001, 0);

        // Field edge on requester 2: (p-1)*2 = p-2
        nxt_a[2*W +: W] = PRIME - 1; nxt_b[2*W +: W] = 2;
        tick(0, 4'b0100, '0, 0);
        for (n = 1; n <= 20; n++) begin
            tick(0, '0, '0, 0);
            if (res_valid[2]) break;
        end
        chk("edge_latency", n, LAT + 1);
        chk("edge_product", res_data[2*W +: W], 61'h1ffffffffffffffd);
        chk("edge_keeps_r0", res_data[W-1:0], 35);
        tick(0, '0, '1, 0);

        // Fairness from reset priority
        tick(1, '0, '1, 0);
        gnt_log.delete();
        for (int k = 0; k < 24; k++) begin rand_ops(); tick(0, '1, '1, 0); end
        chk("fair_count", gnt_log.size() >= 8, 1);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("fair_order", gnt_log[k], k % N);

        // Backpressure on requester 1
        repeat (6) tick(0, '0, '1, 0);
        gnt_log.delete();
        for (int k = 0; k < 12; k++) begin rand_ops(); tick(0, 4'b0010, 4'b1101, 0); end
        cnt = 0;
        foreach (gnt_log[k]) if (gnt_log[k] == 1) cnt++;
        chk("bp_single_grant", cnt, 1);
        chk("bp_held", res_valid[1], 1);
        tick(0, 4'b0010, 4'b1111, 0);
        chk("bp_no_same_cycle", req_ready[1], 0);
        tick(0, 4'b0010, 4'b1101, 0);
        chk("bp_regrant", req_ready[1], 1);
        repeat (6) tick(0, '0, '1, 0);

        // Reset one cycle after issue
        rand_ops();
        tick(0, 4'b1000, '1, 0);
        tick(1, '0, '1, 0);
        repeat (8) tick(0, '0, '1, 0);
        chk("rst_flight_vld", res_valid, 0);
        chk("rst_flight_err", err, 0);

        // Spurious multiplier result with empty tag pipeline
        tick(0, '0, '1, 1);
        repeat (4) tick(0, '0, '1, 0);
        chk("perr_set", err, 1);
        chk("perr_no_res", res_valid, 0);
        tick(1, '0, '1, 0);
        tick(0, '0, '1, 0);
        chk("perr_cleared", err, 0);

        for (int k = 0; k < 600; k++) begin
            rand_ops();
            tick($urandom_range(0, 99) == 0, N'($urandom()), N'($urandom() | $urandom()), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
